main_control_fsm: RTL and testbench

// Multi-cycle RV32I main control unit. Upstream producer of the 2-bit ALUOp consumed by AluControl.

---
 rtl/main_control_fsm.sv | 196 +++++++++++++++++++
 tb/tb_main_control_fsm.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/main_control_fsm.sv
// Multi-cycle RV32I main control unit: sequences FETCH/DECODE/EXECUTE/MEM/WB,
// drives datapath selects and enables, and times out stalled memory handshakes.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 into PC on mem_ready_in
// DECODE   | register read, branch target into ALUOut, dispatch on opcode
// MEMADR   | compute lw/sw effective address
// MEMREAD  | data read at ALUOut, wait for mem_ready_in
// MEMWB    | write load data to register file
// MEMWRITE | store strobe held until mem_ready_in
// EXECR    | R-type ALU operation
// EXECI    | I-type ALU operation
// ALUWB    | write ALUOut to register file
// BEQ      | compare rs1/rs2, load branch target when equal
// JAL      | PC <- target, link address computed for ALUWB
// HALT     | illegal opcode or memory timeout, parked until rst
module main_control_fsm #(
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode_in,
   input  logic             zero_in,
   input  logic             mem_ready_in,
   output logic             pc_write,
   output logic             adr_src,
   output logic             mem_write,
   output logic             ir_write,
   output logic [1:0]       result_src,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       imm_src,
   output logic             reg_write,
   output logic [1:0]       ALUOp_out,
   output logic             illegal_op,
   output logic [CNT_W-1:0] instret
);

   localparam int WC_W = $clog2(WAIT_MAX + 1);
   localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_MAX - 1);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_HALT
   } state_e;

   state_e           state_q, state_d;
   logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             illegal_q, illegal_d;
   logic             timeout, retire, wait_state;
   logic             pc_update, branch;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         wait_cnt_q <= '0;
         instret_q  <= '0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         instret_q  <= instret_d;
         illegal_q  <= illegal_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      retire     = 1'b0;
      wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
      // a ready on the last allowed cycle still wins over the timeout
      timeout    = !mem_ready_in && (wait_cnt_q == WAIT_LAST);
      case (state_q)
         S_FETCH:    if (mem_ready_in) state_d = S_DECODE;
                     else if (timeout) state_d = S_HALT;
         S_DECODE: begin
            case (opcode_in)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_HALT;
            endcase
         end
         S_MEMADR:   state_d = (opcode_in == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (mem_ready_in) state_d = S_MEMWB;
                     else if (timeout) state_d = S_HALT;
         S_MEMWRITE: if (mem_ready_in) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                     end else if (timeout) state_d = S_HALT;
         S_MEMWB, S_ALUWB, S_BEQ: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_FETCH;
      endcase

      illegal_d  = illegal_q | ((state_d == S_HALT) && (state_q != S_HALT));
      instret_d  = retire ? instret_q + CNT_W'(1) : instret_q;
      wait_cnt_d = wait_cnt_q;
      if (state_d != state_q) wait_cnt_d = '0;
      else if (wait_state)    wait_cnt_d = wait_cnt_q + WC_W'(1);
   end

   always_comb begin
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      reg_write  = 1'b0;
      ALUOp_out  = 2'b00;
      pc_update  = 1'b0;
      branch     = 1'b0;
      case (state_q)
         S_FETCH: begin
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = mem_ready_in;
            pc_update  = mem_ready_in;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_MEMREAD:  adr_src = 1'b1;
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
         end
         S_EXECR: begin
            alu_src_a = 2'b10;
            ALUOp_out = 2'b10;
         end
         S_EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            ALUOp_out = 2'b10;
         end
         S_ALUWB:    reg_write = 1'b1;
         S_BEQ: begin
            alu_src_a = 2'b10;
            ALUOp_out = 2'b01;
            branch    = 1'b1;
         end
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_update = 1'b1;
         end
         default: ;
      endcase
      pc_write = pc_update | (branch & zero_in);
      if (rst) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         mem_write = 1'b0;
         reg_write = 1'b0;
      end
   end

   always_comb begin
      case (opcode_in)
         OP_SW:   imm_src = 2'b01;
         OP_BEQ:  imm_src = 2'b10;
         OP_JAL:  imm_src = 2'b11;
         default: imm_src = 2'b00;
      endcase
   end

   assign illegal_op = illegal_q;
   assign instret    = instret_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: an instruction-level model expands each
// instruction into its expected per-cycle control words; a monitor compares them.
module tb_main_control_fsm;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                 P_EXECR, P_EXECI, P_ALUWB, P_BEQ, P_JAL, P_HALT} phase_e;

   typedef struct packed {
      logic       pc_write, adr_src, mem_write, ir_write;
      logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
      logic       reg_write;
      logic [1:0] aluop;
      logic       illegal;
      logic [3:0] instret;
   } obs_t;

   typedef struct {
      obs_t   w;
      phase_e ph;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode_in = OP_R;
   logic       zero_in = 1'b0;
   logic       mem_ready_in = 1'b0;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, ALUOp_out;
   logic [3:0] instret;

   main_control_fsm #(.WAIT_MAX(15), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .opcode_in(opcode_in), .zero_in(zero_in),
      .mem_ready_in(mem_ready_in), .pc_write(pc_write), .adr_src(adr_src),
      .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
      .reg_write(reg_write), .ALUOp_out(ALUOp_out), .illegal_op(illegal_op),
      .instret(instret)
   );

   always #5 clk = ~clk;

   exp_t       exp_q[$];
   int         vectors = 0;
   int         miscompares = 0;
   logic [6:0] op;
   int         n = 0;
   bit         ill = 1'b0;

   function automatic logic [1:0] imm_of(input logic [6:0] o);
      case (o)
         OP_SW:   return 2'b01;
         OP_BEQ:  return 2'b10;
         OP_JAL:  return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   // Expected control word for a cycle spent in phase ph, straight from the state table
   function automatic obs_t word(input phase_e ph, input bit r, input bit z, input bit rs);
      obs_t w;
      w = '0;
      w.imm_src = imm_of(op);
      w.instret = 4'(n % 16);
      w.illegal = ill;
      case (ph)
         P_FETCH:    begin w.alu_src_b = 2'b10; w.result_src = 2'b10; w.ir_write = r; w.pc_write = r; end
         P_DECODE:   begin w.alu_src_a = 2'b01; w.alu_src_b = 2'b01; end
         P_MEMADR:   begin w.alu_src_a = 2'b10; w.alu_src_b = 2'b01; end
         P_MEMREAD:  w.adr_src = 1'b1;
         P_MEMWRITE: begin w.adr_src = 1'b1; w.mem_write = 1'b1; end
         P_MEMWB:    begin w.result_src = 2'b01; w.reg_write = 1'b1; end
         P_EXECR:    begin w.alu_src_a = 2'b10; w.aluop = 2'b10; end
         P_EXECI:    begin w.alu_src_a = 2'b10; w.alu_src_b = 2'b01; w.aluop = 2'b10; end
         P_ALUWB:    w.reg_write = 1'b1;
         P_BEQ:      begin w.alu_src_a = 2'b10; w.aluop = 2'b01; w.pc_write = z; end
         P_JAL:      begin w.alu_src_a = 2'b01; w.alu_src_b = 2'b10; w.pc_write = 1'b1; end
         default:    ;
      endcase
      if (rs) begin
         w.pc_write = 1'b0; w.ir_write = 1'b0; w.mem_write = 1'b0; w.reg_write = 1'b0;
      end
      return w;
   endfunction

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic step(input phase_e ph, input bit r, input bit z, input bit rs);
      exp_t e;
      mem_ready_in = r;
      zero_in      = z;
      rst          = rs;
      opcode_in    = op;
      e.w  = word(ph, r, z, rs);
      e.ph = ph;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic retire();
      n = (n + 1) % 16;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      n   = 0;
      ill = 1'b0;
   endtask

   task automatic reset_from(input phase_e ph);
      step(ph, rb(), rb(), 1'b1);
      n   = 0;
      ill = 1'b0;
   endtask

   task automatic run_instr(input logic [6:0] o, input int fw, input int mw, input bit z);
      op = o;
      for (int i = 0; i < fw; i++) step(P_FETCH, 1'b0, rb(), 1'b0);
      step(P_FETCH, 1'b1, rb(), 1'b0);
      step(P_DECODE, rb(), rb(), 1'b0);
      case (o)
         OP_LW: begin
            step(P_MEMADR, rb(), rb(), 1'b0);
            for (int i = 0; i < mw; i++) step(P_MEMREAD, 1'b0, rb(), 1'b0);
            step(P_MEMREAD, 1'b1, rb(), 1'b0);
            step(P_MEMWB, rb(), rb(), 1'b0);
            retire();
         end
         OP_SW: begin
            step(P_MEMADR, rb(), rb(), 1'b0);
            for (int i = 0; i < mw; i++) step(P_MEMWRITE, 1'b0, rb(), 1'b0);
            step(P_MEMWRITE, 1'b1, rb(), 1'b0);
            retire();
         end
         OP_R:   begin step(P_EXECR, rb(), rb(), 1'b0); step(P_ALUWB, rb(), rb(), 1'b0); retire(); end
         OP_I:   begin step(P_EXECI, rb(), rb(), 1'b0); step(P_ALUWB, rb(), rb(), 1'b0); retire(); end
         OP_BEQ: begin step(P_BEQ, rb(), z, 1'b0); retire(); end
         OP_JAL: begin step(P_JAL, rb(), rb(), 1'b0); step(P_ALUWB, rb(), rb(), 1'b0); retire(); end
         default: begin
            ill = 1'b1;
            for (int i = 0; i < 20; i++) step(P_HALT, rb(), rb(), 1'b0);
            reset_from(P_HALT);
         end
      endcase
   endtask

   always @(negedge clk) begin
      obs_t got;
      exp_t e;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = '{pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                 alu_src_b, imm_src, reg_write, ALUOp_out, illegal_op, instret};
         vectors++;
         if (got !== e.w) begin
            miscompares++;
            $display("FAIL ctrl_word phase=%s got=%b exp=%b (pcw adr mw irw res srca srcb imm rw aluop ill instret)",
                     e.ph.name(), got, e.w);
         end
      end
   end

   logic [6:0] legal_ops [6] = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};

   initial begin
      op = OP_R;
      do_reset();

      run_instr(OP_R, 0, 0, 1'b0);
      run_instr(OP_LW, 0, 3, 1'b0);
      run_instr(OP_BEQ, 0, 0, 1'b1);
      run_instr(OP_BEQ, 0, 0, 1'b0);
      run_instr(OP_R, 14, 0, 1'b0);
      run_instr(OP_SW, 2, 14, 1'b0);
      run_instr(OP_JAL, 1, 0, 1'b0);
      run_instr(OP_I, 0, 0, 1'b0);

      for (int k = 0; k < 40; k++)
         run_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 14),
                   $urandom_range(0, 6), rb());

      // reset while a store is acknowledged: no retire, strobe suppressed
      op = OP_SW;
      step(P_FETCH, 1'b1, rb(), 1'b0);
      step(P_DECODE, rb(), rb(), 1'b0);
      step(P_MEMADR, rb(), rb(), 1'b0);
      step(P_MEMWRITE, 1'b1, rb(), 1'b1);
      n = 0;
      ill = 1'b0;
      run_instr(OP_R, 0, 0, 1'b0);

      run_instr(OP_BAD, 0, 0, 1'b0);
      run_instr(OP_LW, 0, 0, 1'b0);

      op = OP_R;
      for (int i = 0; i < 15; i++) step(P_FETCH, 1'b0, rb(), 1'b0);
      ill = 1'b1;
      for (int i = 0; i < 3; i++) step(P_HALT, rb(), rb(), 1'b0);
      reset_from(P_HALT);

      op = OP_LW;
      step(P_FETCH, 1'b1, rb(), 1'b0);
      step(P_DECODE, rb(), rb(), 1'b0);
      step(P_MEMADR, rb(), rb(), 1'b0);
      for (int i = 0; i < 15; i++) step(P_MEMREAD, 1'b0, rb(), 1'b0);
      ill = 1'b1;
      for (int i = 0; i < 3; i++) step(P_HALT, rb(), rb(), 1'b0);
      reset_from(P_HALT);
      run_instr(OP_I, 0, 0, 1'b0);

      repeat (2) @(posedge clk);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
